// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and default sizes for the timer/capture blocks
package timer_pkg;

  localparam int CNT_W_DEF       = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEAS_HI = 2'd2,
    MEAS_LO = 2'd3
  } meas_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer with rise/fall edge detection
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  // fill_q marks when prev_q holds a genuinely sampled value, so a level that
  // is already high when reset releases is not mistaken for a rising edge
  logic [STAGES:0]   fill_q;

  // shift the input through the synchronizer, keep one delayed copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
    end
  end

  assign rise_o = fill_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = fill_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/pwm_meas_core.sv
// rtl/pwm_meas_core.sv - PWM period / active-time measurement with timeout
module pwm_meas_core
  import timer_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             inv,
  input  logic             pre_en,
  input  logic [15:0]      pre_val,
  input  logic [CNT_W-1:0] timeout_val,
  input  logic             res_ack,
  input  logic             clr_status,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] period_val,
  output logic [CNT_W-1:0] high_val,
  output logic             res_valid,
  output logic             overrun,
  output logic             timeout,
  output logic             busy,
  output logic             irq
);

  meas_state_e      state, state_nxt;
  logic             rise, fall, tick, measuring;
  logic             complete, to_evt, done_q;
  logic [15:0]      pre_cnt;
  logic [CNT_W-1:0] period_cnt, high_cnt, period_inc, high_inc;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (pwm_i ^ inv),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign tick       = !pre_en || (pre_cnt == '0);
  assign measuring  = (state == MEAS_HI) || (state == MEAS_LO);
  assign busy       = (state != IDLE);
  // saturating increments; the captured result includes the current tick
  assign period_inc = (&period_cnt) ? period_cnt : period_cnt + 1'b1;
  assign high_inc   = (&high_cnt)   ? high_cnt   : high_cnt + 1'b1;

  // next-state logic plus the result / timeout event strobes
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    to_evt    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      to_evt = measuring && tick && (timeout_val != '0) && (period_inc == timeout_val);
      case (state)
        IDLE:    if (!done_q) state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEAS_HI;
        MEAS_HI: begin
          if (to_evt)    state_nxt = ARM;
          else if (fall) state_nxt = MEAS_LO;
        end
        MEAS_LO: begin
          if (rise) begin
            complete  = 1'b1;
            state_nxt = mode ? MEAS_HI : IDLE;
          end else if (to_evt) begin
            state_nxt = ARM;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // state register and single-shot lockout (released by en going low)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!en)                   done_q <= 1'b0;
      else if (complete && !mode) done_q <= 1'b1;
    end
  end

  // prescaler: restarts on every rise so ticks align with the PWM edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pre_cnt <= '0;
    else if (!en)              pre_cnt <= '0;
    else if (rise)             pre_cnt <= pre_val;
    else if (pre_en) begin
      if (pre_cnt == '0)       pre_cnt <= pre_val;
      else                     pre_cnt <= pre_cnt - 1'b1;
    end
  end

  // period and active-time counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (!en || rise) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (tick && measuring) begin
      period_cnt <= period_inc;
      if (state == MEAS_HI) high_cnt <= high_inc;
    end
  end

  // result registers, sticky status flags and the interrupt pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_val <= '0;
      high_val   <= '0;
      res_valid  <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq <= complete || to_evt;
      if (complete) begin
        period_val <= tick ? period_inc : period_cnt;
        high_val   <= high_cnt;
        res_valid  <= 1'b1;
      end else if (res_ack) begin
        res_valid  <= 1'b0;
      end
      if (complete && res_valid && !res_ack) overrun <= 1'b1;
      else if (clr_status)                    overrun <= 1'b0;
      if (to_evt)          timeout <= 1'b1;
      else if (clr_status) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_meas_core.sv
// tb/tb_pwm_meas_core.sv - directed self-checking bench for pwm_meas_core
module tb_pwm_meas_core;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, inv, pre_en, res_ack, clr_status, pwm_i;
  logic [15:0] pre_val;
  logic [31:0] timeout_val;
  logic [31:0] period_val, high_val;
  logic        res_valid, overrun, timeout, busy, irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0, irq_cnt = 0, irq_last = 0, irq_gap = 0;
  int base;
  logic [31:0] sv_period, sv_high;

  typedef struct {
    logic        pre_en;
    logic [15:0] pre_val;
    int          hi;
    int          lo;
    logic [31:0] exp_period;
    logic [31:0] exp_high;
  } vec_t;

  vec_t vecs[6];

  pwm_meas_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .inv         (inv),
    .pre_en      (pre_en),
    .pre_val     (pre_val),
    .timeout_val (timeout_val),
    .res_ack     (res_ack),
    .clr_status  (clr_status),
    .pwm_i       (pwm_i),
    .period_val  (period_val),
    .high_val    (high_val),
    .res_valid   (res_valid),
    .overrun     (overrun),
    .timeout     (timeout),
    .busy        (busy),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // irq monitor: pulse count and spacing between the last two pulses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (irq) begin
      irq_cnt  <= irq_cnt + 1;
      irq_gap  <= cyc - irq_last;
      irq_last <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulses(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_i = 1'b1;
      tick(hi);
      pwm_i = 1'b0;
      tick(lo);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'd0, 3,  7,  32'd10, 32'd3};
    vecs[1] = '{1'b0, 16'd0, 1,  1,  32'd2,  32'd1};
    vecs[2] = '{1'b0, 16'd0, 20, 5,  32'd25, 32'd20};
    vecs[3] = '{1'b1, 16'd3, 40, 40, 32'd20, 32'd10};
    vecs[4] = '{1'b1, 16'd0, 5,  5,  32'd10, 32'd5};
    vecs[5] = '{1'b1, 16'd4, 10, 13, 32'd4,  32'd2};

    rst_n = 1'b0; en = 1'b0; mode = 1'b1; inv = 1'b0; pre_en = 1'b0;
    pre_val = 16'd0; timeout_val = 32'd0; res_ack = 1'b0; clr_status = 1'b0;
    pwm_i = 1'b1;
    tick(3);
    chk("rst_period", period_val, 0);
    chk("rst_high", high_val, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);

    // input already high at reset release must not count as a rise
    rst_n = 1'b1; en = 1'b1;
    base = irq_cnt;
    tick(10);
    chk("hi_release_busy", busy, 1);
    pwm_i = 1'b0; tick(5);
    pwm_i = 1'b1; tick(3);
    pwm_i = 1'b0; tick(4);
    pwm_i = 1'b1; tick(6);
    chk("hi_release_irqs", irq_cnt - base, 1);
    chk("hi_release_period", period_val, 7);
    chk("hi_release_high", high_val, 3);

    for (int i = 0; i < 6; i++) begin
      en = 1'b0; pwm_i = 1'b0;
      pre_en = vecs[i].pre_en; pre_val = vecs[i].pre_val; mode = 1'b1;
      res_ack = 1'b1; clr_status = 1'b1;
      tick(2);
      res_ack = 1'b0; clr_status = 1'b0; en = 1'b1;
      tick(5);
      base = irq_cnt;
      pulses(vecs[i].hi, vecs[i].lo, 4);
      tick(8);
      chk($sformatf("vec%0d_period", i), period_val, vecs[i].exp_period);
      chk($sformatf("vec%0d_high", i), high_val, vecs[i].exp_high);
      chk($sformatf("vec%0d_irqs", i), irq_cnt - base, 3);
      chk($sformatf("vec%0d_gap", i), irq_gap, vecs[i].hi + vecs[i].lo);
      chk($sformatf("vec%0d_valid", i), res_valid, 1);
      chk($sformatf("vec%0d_overrun", i), overrun, 1);
    end

    // clear sticky status, result stays pending
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    chk("clr_overrun", overrun, 0);
    chk("clr_keeps_valid", res_valid, 1);

    // ack in the very cycle a new result lands: stays valid, no overrun
    pwm_i = 1'b1;
    tick(2);
    res_ack = 1'b1;
    tick(1);
    res_ack = 1'b0;
    chk("ack_coincide_valid", res_valid, 1);
    chk("ack_coincide_overrun", overrun, 0);
    chk("ack_coincide_irq", irq, 1);
    pwm_i = 1'b0;
    res_ack = 1'b1; tick(1); res_ack = 1'b0;
    chk("ack_clears_valid", res_valid, 0);

    // timeout after 50 ticks with the input stuck high
    en = 1'b0; pre_en = 1'b0; timeout_val = 32'd50; clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0; en = 1'b1;
    tick(5);
    sv_period = period_val; sv_high = high_val;
    base = irq_cnt;
    pwm_i = 1'b1;
    tick(52);
    chk("to_not_early", timeout, 0);
    tick(1);
    chk("to_set", timeout, 1);
    chk("to_irq", irq, 1);
    tick(1);
    chk("to_irq_single", irq, 0);
    tick(60);
    chk("to_irq_count", irq_cnt - base, 1);
    chk("to_busy_arm", busy, 1);
    chk("to_period_kept", period_val, sv_period);
    chk("to_high_kept", high_val, sv_high);
    pwm_i = 1'b0;

    // single-shot: one result, then idle until en toggles
    en = 1'b0; mode = 1'b0; timeout_val = 32'd0; clr_status = 1'b1; res_ack = 1'b1;
    tick(1);
    clr_status = 1'b0; res_ack = 1'b0; en = 1'b1;
    tick(5);
    base = irq_cnt;
    pulses(3, 7, 3);
    tick(8);
    chk("ss_irqs", irq_cnt - base, 1);
    chk("ss_period", period_val, 10);
    chk("ss_high", high_val, 3);
    chk("ss_valid", res_valid, 1);
    chk("ss_idle", busy, 0);
    en = 1'b0; tick(1); en = 1'b1; tick(1);
    chk("ss_rearm", busy, 1);
    pulses(4, 6, 2);
    tick(8);
    chk("ss_second", irq_cnt - base, 2);
    chk("ss_second_period", period_val, 10);

    // en dropped in MEAS_HI: abort, keep results
    mode = 1'b1;
    en = 1'b0; tick(1); en = 1'b1; tick(3);
    base = irq_cnt;
    pwm_i = 1'b1; tick(6);
    en = 1'b0; tick(1);
    chk("endrop_busy", busy, 0);
    tick(3);
    chk("endrop_period", period_val, 10);
    chk("endrop_high", high_val, 4);
    chk("endrop_valid", res_valid, 1);
    chk("endrop_irqs", irq_cnt - base, 0);
    pwm_i = 1'b0;

    // reset asserted in MEAS_LO: immediate abort to reset values
    en = 1'b1; tick(3);
    pwm_i = 1'b1; tick(4);
    pwm_i = 1'b0; tick(6);
    rst_n = 1'b0;
    #1;
    chk("rstmid_period", period_val, 0);
    chk("rstmid_valid", res_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_irq", irq, 0);
    tick(3);
    chk("rstmid_irqs", irq_cnt - base, 0);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
